// File: rtl/rr_mux_arbiter_pkg.sv
// Shared encodings and winner-search helpers for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

  localparam logic [1:0] SEL_IN0 = 2'd0;
  localparam logic [1:0] SEL_IN1 = 2'd1;
  localparam logic [1:0] SEL_IN2 = 2'd2;
  localparam logic [1:0] SEL_IN3 = 2'd3;

  localparam int MAX_HOLD_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // First requester at or after start in cyclic order; the lowest offset wins
  // because it is assigned last.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) pick = idx;
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// Shared 1-bit 4:1 datapath mux.
module mux_4to1
  import rr_mux_arbiter_pkg::*;
(
  input  logic [1:0] sel,
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  output logic       out
);

  always_comb begin
    out = in0;
    unique case (sel)
      SEL_IN0: out = in0;
      SEL_IN1: out = in1;
      SEL_IN2: out = in2;
      SEL_IN3: out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter owning a 4:1 mux, with a hold limit per grant.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       in3,
  input  logic       in2,
  input  logic       in1,
  input  logic       in0,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       out
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d, ptr_q, ptr_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic       owner_req, others;
  logic [1:0] idle_sel, rot_sel;

  assign owner_req = req[sel_q];
  assign others    = |(req & ~onehot(sel_q));
  assign idle_sel  = pick(req, ptr_q);
  // Searching from owner+1 never returns the owner while others are pending.
  assign rot_sel   = pick(req, sel_q + 2'd1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d  = 4'b0000;
        busy_d = 1'b0;
        if (|req) begin
          state_d = ST_GRANT;
          sel_d   = idle_sel;
          gnt_d   = onehot(idle_sel);
          busy_d  = 1'b1;
          hold_d  = HOLD_ONE;
        end
      end
      ST_GRANT: begin
        if (!owner_req && !others) begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          ptr_d   = sel_q + 2'd1;
        end else if (!owner_req || (hold_q == HOLD_MAX && others)) begin
          // Release or forced rotation hands over on the same edge.
          sel_d  = rot_sel;
          gnt_d  = onehot(rot_sel);
          hold_d = HOLD_ONE;
          ptr_d  = sel_q + 2'd1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_IN0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

  mux_4to1 u_mux (
    .sel (sel_q),
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .out (out)
  );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed vector bench for rr_mux_arbiter (MAX_HOLD=4).
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       in3, in2, in1, in0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       out;

  int total = 0;
  int bad   = 0;

  rr_mux_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .in3   (in3),
    .in2   (in2),
    .in1   (in1),
    .in0   (in0),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy),
    .out   (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] rq;
    logic [3:0] d;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic       o;
  } vec_t;

  vec_t tv[23];

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] d);
    @(negedge clk);
    rst_n = r;
    req   = rq;
    {in3, in2, in1, in0} = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] g, input logic [1:0] s,
                     input logic b, input logic o);
    total++;
    if (gnt !== g || sel !== s || busy !== b || out !== o) begin
      bad++;
      $display("FAIL %s: got gnt=%b sel=%0d busy=%b out=%b, want gnt=%b sel=%0d busy=%b out=%b",
               name, gnt, sel, busy, out, g, s, b, o);
    end
    total++;
    if (!($onehot0(gnt)) || (gnt[sel] !== busy)) begin
      bad++;
      $display("FAIL %s-invariant: gnt=%b sel=%0d busy=%b", name, gnt, sel, busy);
    end
  endtask

  initial begin
    logic [3:0] eg;
    logic [3:0] d;
    rst_n = 1'b0;
    req   = 4'b0000;
    {in3, in2, in1, in0} = 4'b0000;

    //          rst   req      in       gnt      sel  busy  out
    tv[0]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 4'b1111, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    tv[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tv[5]  = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
    tv[6]  = '{1'b1, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 4'b0101, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    tv[8]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
    tv[10] = '{1'b1, 4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
    tv[11] = '{1'b1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tv[12] = '{1'b1, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1};
    tv[13] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tv[14] = '{1'b1, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    tv[15] = '{1'b1, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    tv[16] = '{1'b1, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    tv[17] = '{1'b1, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    tv[18] = '{1'b1, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    tv[19] = '{1'b1, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    tv[20] = '{1'b1, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    tv[21] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1};
    tv[22] = '{1'b1, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};

    foreach (tv[i]) begin
      step(tv[i].r, tv[i].rq, tv[i].d);
      chk($sformatf("vec%0d", i), tv[i].g, tv[i].s, tv[i].b, tv[i].o);
    end

    // Single requester keeps the mux indefinitely, then releases to idle.
    step(1'b0, 4'b0000, 4'b0000);
    chk("solo-rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      d = 4'($urandom_range(0, 15));
      step(1'b1, 4'b0100, d);
      chk($sformatf("solo-hold%0d", k), 4'b0100, 2'd2, 1'b1, d[2]);
    end
    step(1'b1, 4'b0000, 4'b0100);
    chk("solo-drop", 4'b0000, 2'd2, 1'b0, 1'b1);

    // Two continuous requesters alternate every MAX_HOLD cycles.
    step(1'b0, 4'b0011, 4'b0000);
    chk("alt-rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      d  = 4'($urandom_range(0, 15));
      eg = ((k / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
      step(1'b1, 4'b0011, d);
      chk($sformatf("alt%0d", k), eg, (eg == 4'b0001) ? 2'd0 : 2'd1, 1'b1,
          (eg == 4'b0001) ? d[0] : d[1]);
    end

    // Late arrival after saturation rotates on the very next edge.
    step(1'b0, 4'b0000, 4'b0000);
    for (int k = 0; k < 6; k++) step(1'b1, 4'b0010, 4'b0010);
    chk("sat-hold", 4'b0010, 2'd1, 1'b1, 1'b1);
    step(1'b1, 4'b0011, 4'b0001);
    chk("sat-rotate", 4'b0001, 2'd0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
